// File: rtl/rf_param_pkg.sv
// rf_pkg: shared defaults, FSM state type and address-width helper for rf_param
package rf_pkg;
    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_NRD   = 2;
    typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;
    function automatic int rf_aw(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/rf_param_clear_seq.sv
// rf_clear_seq: clear counter and FSM that zero the array one entry per cycle after reset
// ports: clk, rst (sync, active-high), busy (clear in progress), clr_we/clr_addr (array clear write)
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    localparam int AW = rf_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);
    rf_state_t     state, state_nxt;
    logic [AW-1:0] clr_idx;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == RF_CLEAR) clr_idx <= clr_idx + 1'b1;
        end
    end
    always_comb state_nxt = (state == RF_CLEAR && clr_idx == AW'(DEPTH - 1)) ? RF_RUN : state;
    always_comb begin
        busy     = state == RF_CLEAR;
        clr_we   = busy && !rst;
        clr_addr = clr_idx;
    end
endmodule

// File: rtl/rf_param.sv
// rf_param: parametrised multi-port register file with sync reads, write bypass and reset clear
// ports: clk, rst (sync, active-high), we/wa/wd (write port), ra (NRD packed read addresses),
//        rd (NRD packed registered read data), busy (clear sequence running)
module rf_param
    import rf_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NRD      = RF_NRD,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW = rf_aw(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        wa,
    input  logic [WIDTH-1:0]     wd,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*WIDTH-1:0] rd,
    output logic                 busy
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic             clr_we, wr_ok, mem_we;
    logic [AW-1:0]    clr_addr, mem_wa;
    logic [WIDTH-1:0] mem_wd;
    rf_clear_seq #(.DEPTH(DEPTH)) u_seq (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );
    // a user write only lands in RUN, outside reset, and not on a protected entry 0
    always_comb begin
        wr_ok  = we && !busy && !rst && !(ZERO_REG && wa == '0);
        mem_we = clr_we || wr_ok;
        mem_wa = clr_we ? clr_addr : wa;
        mem_wd = clr_we ? '0 : wd;
    end
    always_ff @(posedge clk) if (mem_we) mem[mem_wa] <= mem_wd;
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] q;
        assign a = ra[g*AW +: AW];
        always_ff @(posedge clk)
            q <= (rst || busy || (ZERO_REG && a == '0)) ? '0 : (BYPASS && wr_ok && wa == a) ? wd : mem[a];
        assign rd[g*WIDTH +: WIDTH] = q;
    end
endmodule

// File: tb/tb_rf_param.sv
// tb_rf_param: scoreboard bench for three rf_param configurations driven in lockstep
module tb_rf_param;
    logic clk = 1'b0;
    logic rst, we;
    logic [4:0] wa_i;
    logic [63:0] wd_i;
    logic [4:0] addr [4];
    logic [9:0] ra_ab;
    logic [15:0] ra_c;
    logic [63:0] rd_a, rd_b;
    logic [255:0] rd_c;
    logic busy_a, busy_b, busy_c;
    always #5 clk = ~clk;
    assign ra_ab = {addr[1], addr[0]};
    assign ra_c = {addr[3][3:0], addr[2][3:0], addr[1][3:0], addr[0][3:0]};
    rf_param #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .we(we), .wa(wa_i), .wd(wd_i[31:0]), .ra(ra_ab), .rd(rd_a), .busy(busy_a));
    rf_param #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .we(we), .wa(wa_i), .wd(wd_i[31:0]), .ra(ra_ab), .rd(rd_b), .busy(busy_b));
    rf_param #(.WIDTH(64), .DEPTH(16), .NRD(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
        .clk(clk), .rst(rst), .we(we), .wa(wa_i[3:0]), .wd(wd_i), .ra(ra_c), .rd(rd_c), .busy(busy_c));
    typedef struct {int d; int p; logic [63:0] v;} exp_t;
    typedef struct {logic w; logic [4:0] wa; logic [63:0] wd; logic [3:0][4:0] a; logic [31:0] e0;} vec_t;
    exp_t sbq[$];
    vec_t vt[9];
    int checks = 0, fails = 0;
    string tag = "reset";
    logic [63:0] mm [3][32];
    bit   mbusy [3];
    int   midx [3];
    int   dep [3] = '{32, 32, 16};
    int   np [3] = '{2, 2, 4};
    bit   zr [3] = '{1'b1, 1'b0, 1'b1};
    bit   bp [3] = '{1'b1, 1'b0, 1'b1};
    logic [4:0]  amask [3] = '{5'd31, 5'd31, 5'd15};
    logic [63:0] dmask [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    function automatic logic [63:0] act(int d, int p);
        if (p == 4) return {63'b0, d == 0 ? busy_a : d == 1 ? busy_b : busy_c};
        if (d == 0) return {32'b0, rd_a[p*32 +: 32]};
        if (d == 1) return {32'b0, rd_b[p*32 +: 32]};
        return rd_c[p*64 +: 64];
    endfunction
    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask
    task automatic cyc(input bit r, input bit w, input logic [4:0] wa_v, input logic [63:0] wd_v,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
        exp_t e;
        rst = r; we = w; wa_i = wa_v; wd_i = wd_v;
        addr[0] = a0; addr[1] = a1; addr[2] = a2; addr[3] = a3;
        for (int d = 0; d < 3; d++) begin
            logic [4:0] wam;
            bit prot;
            wam = wa_v & amask[d];
            prot = zr[d] && wam == 5'd0;
            for (int p = 0; p < np[d]; p++) begin
                logic [4:0] ram;
                ram = addr[p] & amask[d];
                e.d = d; e.p = p;
                if (r || mbusy[d] || (zr[d] && ram == 5'd0)) e.v = '0;
                else if (bp[d] && w && !prot && wam == ram) e.v = wd_v & dmask[d];
                else e.v = mm[d][ram];
                sbq.push_back(e);
            end
            if (r) begin
                mbusy[d] = 1'b1;
                midx[d] = 0;
            end else if (mbusy[d]) begin
                if (midx[d] == dep[d] - 1) begin
                    mbusy[d] = 1'b0;
                    for (int k = 0; k < 32; k++) mm[d][k] = '0;
                end
                midx[d]++;
            end else if (w && !prot) mm[d][wam] = wd_v & dmask[d];
            e.d = d; e.p = 4; e.v = {63'b0, mbusy[d]};
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("%s d%0d p%0d", tag, e.d, e.p), act(e.d, e.p), e.v);
        end
    endtask
    task automatic run_clear(input bit w, output int n, output int nc);
        n = 0; nc = 0;
        do begin
            cyc(1'b0, w, 5'd3, 64'hFF, 5'(n), 5'd3, 5'(31 - n), 5'd3);
            n++;
            if (!busy_c && nc == 0) nc = n;
        end while (busy_a && n < 100);
        if (busy_a) chk({tag, " clear_timeout"}, 64'(busy_a), 64'd0);
    endtask
    initial begin
        int n, nc;
        vt[0] = '{1'b1, 5'd5, 64'hCAFE0000_DEADBEEF, {5'd0, 5'd0, 5'd0, 5'd0}, 32'h0};
        vt[1] = '{1'b0, 5'd0, 64'h0, {5'd5, 5'd5, 5'd5, 5'd5}, 32'hDEADBEEF};
        vt[2] = '{1'b1, 5'd0, 64'h1234, {5'd0, 5'd0, 5'd0, 5'd0}, 32'h0};
        vt[3] = '{1'b0, 5'd0, 64'h0, {5'd0, 5'd0, 5'd0, 5'd0}, 32'h0};
        vt[4] = '{1'b1, 5'd7, 64'h11, {5'd5, 5'd5, 5'd5, 5'd5}, 32'hDEADBEEF};
        vt[5] = '{1'b1, 5'd7, 64'h5555_0000_0000_0022, {5'd7, 5'd7, 5'd7, 5'd7}, 32'h22};
        vt[6] = '{1'b0, 5'd0, 64'h0, {5'd7, 5'd7, 5'd7, 5'd7}, 32'h22};
        vt[7] = '{1'b1, 5'd9, 64'hAAAA, {5'd7, 5'd9, 5'd7, 5'd9}, 32'hAAAA};
        vt[8] = '{1'b0, 5'd0, 64'h0, {5'd0, 5'd7, 5'd5, 5'd9}, 32'hAAAA};
        cyc(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        cyc(1'b1, 1'b1, 5'd4, 64'h77, 5'd4, 5'd4, 5'd4, 5'd4);
        tag = "clear";
        run_clear(1'b0, n, nc);
        chk("clear_len_a", 64'(n), 64'd32);
        chk("clear_len_c", 64'(nc), 64'd16);
        tag = "read_all";
        for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i), 5'(i), 5'(31 - i));
        tag = "table";
        for (int i = 0; i < 9; i++) begin
            cyc(1'b0, vt[i].w, vt[i].wa, vt[i].wd, vt[i].a[0], vt[i].a[1], vt[i].a[2], vt[i].a[3]);
            chk($sformatf("table%0d_a0", i), act(0, 0), {32'b0, vt[i].e0});
        end
        tag = "wr_in_clear";
        cyc(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        run_clear(1'b1, n, nc);
        cyc(1'b0, 1'b0, 5'd0, 64'h0, 5'd3, 5'd3, 5'd3, 5'd3);
        chk("wr_in_clear_a3", act(0, 0), 64'h0);
        tag = "mid_clear";
        cyc(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 5'd0, 64'h0, 5'd1, 5'd2, 5'd3, 5'd4);
        cyc(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        run_clear(1'b0, n, nc);
        chk("restart_len_a", 64'(n), 64'd32);
        chk("restart_len_c", 64'(nc), 64'd16);
        tag = "post";
        cyc(1'b0, 1'b1, 5'd12, 64'h0123_4567_89AB_CDEF, 5'd12, 5'd12, 5'd12, 5'd12);
        cyc(1'b0, 1'b0, 5'd0, 64'h0, 5'd12, 5'd9, 5'd12, 5'd7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
